// File: rtl/romsel_pkg.sv
// romsel_pkg: shared state encoding and bus constants for the ROM-select IO write initiator
package romsel_pkg;
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_HOLD, S_GAP} state_t;
  localparam logic [15:0] ROMSEL_IO_ADR = 16'hDF00;
  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACTIVE = 1'b0;
endpackage

// File: rtl/romsel_req_fifo.sv
// romsel_req_fifo: DEPTH x 8 request queue; pushes while full are dropped, async reset to empty
module romsel_req_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       wclk,
  input  logic       reset_b,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge wclk or negedge reset_b)
    if (!reset_b) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge wclk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/romsel_iowr_gen.sv
// romsel_iowr_gen: queues ROM numbers and issues Z80-style IO writes to &DFxx, keeping a shadow copy.
// Define ROMSEL_WAIT_EN to let wait_b stretch the wait phase of each cycle.
module romsel_iowr_gen
  import romsel_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int AUTO_WAIT = 1,
  parameter int GAP = 1
) (
  input  logic        wclk,
  input  logic        reset_b,
  input  logic        req_valid,
  input  logic [7:0]  req_rom,
  output logic        req_ready,
  output logic        busy,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        ioreq_b,
  output logic        wr_b,
  output logic        rd_b,
  input  logic        wait_b,
  output logic [7:0]  romsel_shadow
);
  state_t state;
  logic [7:0] cnt, head;
  logic empty, full, pop, wait_ok;
`ifdef ROMSEL_WAIT_EN
  assign wait_ok = wait_b;
`else
  logic unused_wait;
  assign unused_wait = wait_b;
  assign wait_ok = 1'b1;
`endif
  assign pop = state == S_IDLE && !empty;
  assign busy = !empty || state != S_IDLE;
  assign req_ready = !full;
  assign rd_b = STROBE_IDLE;
  romsel_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .wclk(wclk), .reset_b(reset_b), .push(req_valid), .pop(pop),
    .din(req_rom), .dout(head), .full(full), .empty(empty)
  );
  // outputs are loaded on the edge entering each state, so pins reflect the current state
  always_ff @(posedge wclk or negedge reset_b)
    if (!reset_b) begin
      state <= S_IDLE;
      cnt <= '0;
      adr <= '0;
      data_out <= '0;
      data_oe <= 1'b0;
      ioreq_b <= STROBE_IDLE;
      wr_b <= STROBE_IDLE;
      romsel_shadow <= '0;
    end else
      case (state)
        S_IDLE: if (!empty) begin
          state <= S_T1;
          adr <= ROMSEL_IO_ADR;
          data_out <= head;
          data_oe <= 1'b1;
        end
        S_T1: begin
          state <= S_T2;
          ioreq_b <= STROBE_ACTIVE;
          wr_b <= STROBE_ACTIVE;
        end
        S_T2: if (AUTO_WAIT > 0 || wait_ok) begin
          state <= AUTO_WAIT > 0 ? S_TW : S_T3;
          cnt <= 8'(AUTO_WAIT > 0 ? AUTO_WAIT - 1 : 0);
        end
        S_TW: if (wait_ok) begin
          state <= cnt == '0 ? S_T3 : S_TW;
          cnt <= cnt == '0 ? cnt : cnt - 8'd1;
        end
        S_T3: begin
          state <= S_HOLD;
          ioreq_b <= STROBE_IDLE;
          wr_b <= STROBE_IDLE;
          romsel_shadow <= data_out;
        end
        S_HOLD: begin
          state <= S_GAP;
          adr <= '0;
          data_out <= '0;
          data_oe <= 1'b0;
          cnt <= 8'(GAP - 1);
        end
        S_GAP: begin
          state <= cnt == '0 ? S_IDLE : S_GAP;
          cnt <= cnt == '0 ? cnt : cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_romsel_iowr_gen.sv
// tb_romsel_iowr_gen: directed stimulus against a cycle-offset model of the IO write protocol
module tb_romsel_iowr_gen;
  localparam int DEPTH = 2, AW = 1, GP = 1;
`ifdef ROMSEL_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic wclk = 0, reset_b = 0, req_valid = 0, wait_b = 1;
  logic [7:0] req_rom = 0;
  logic req_ready, busy, data_oe, ioreq_b, wr_b, rd_b;
  logic [15:0] adr;
  logic [7:0] data_out, romsel_shadow;
  int vectors = 0, miscompares = 0;
  romsel_iowr_gen #(.FIFO_DEPTH(DEPTH), .AUTO_WAIT(AW), .GAP(GP)) dut (
    .wclk(wclk), .reset_b(reset_b), .req_valid(req_valid), .req_rom(req_rom),
    .req_ready(req_ready), .busy(busy), .adr(adr), .data_out(data_out),
    .data_oe(data_oe), .ioreq_b(ioreq_b), .wr_b(wr_b), .rd_b(rd_b),
    .wait_b(wait_b), .romsel_shadow(romsel_shadow)
  );
  always #5 wclk = ~wclk;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  // model: a bus cycle is an offset d from its T1 edge; ext counts wait-stretch cycles
  logic [7:0] mq[$];
  logic [7:0] cur = 0, mshadow = 0, latch = 0;
  bit active = 0, chk_en = 0, prev_low = 0, prev_oe = 0;
  int d = 0, ext = 0, cyc = 0;
  int t1_time[$];
  logic [7:0] t1_rom[$];

  task automatic mclear();
    mq.delete();
    active = 0;
    mshadow = 0;
    latch = 0;
    prev_low = 0;
    prev_oe = 0;
  endtask

  task automatic mstep();
    int pre;
    bit acc;
    if (!reset_b) begin
      mclear();
      return;
    end
    pre = mq.size();
    acc = req_valid && pre < DEPTH;
    if (!active) begin
      if (pre > 0) begin
        cur = mq.pop_front();
        active = 1;
        d = 0;
        ext = 0;
      end
    end else begin
      if (WEN && !wait_b && d >= (AW > 0 ? 2 : 1) && d <= 1 + AW + ext) ext++;
      if (d == 3 + AW + ext + GP) active = 0;
      else begin
        d++;
        if (d == 3 + AW + ext) mshadow = cur;
      end
    end
    if (acc) mq.push_back(req_rom);
  endtask

  task automatic mcompare();
    logic [15:0] ea;
    logic [7:0] ed;
    logic eo, es;
    ea = 0; ed = 0; eo = 0; es = 1;
    if (active) begin
      if (d <= 3 + AW + ext) begin
        ea = 16'hDF00;
        ed = cur;
        eo = 1;
      end
      es = !(d >= 1 && d <= 2 + AW + ext);
    end
    chk("adr", adr, ea);
    chk("data_out", {8'h0, data_out}, {8'h0, ed});
    chk("data_oe", {15'h0, data_oe}, {15'h0, eo});
    chk("ioreq_b", {15'h0, ioreq_b}, {15'h0, es});
    chk("wr_b", {15'h0, wr_b}, {15'h0, es});
    chk("rd_b", {15'h0, rd_b}, 16'h1);
    chk("busy", {15'h0, busy}, {15'h0, (mq.size() > 0 || active)});
    chk("req_ready", {15'h0, req_ready}, {15'h0, (mq.size() < DEPTH)});
    chk("shadow", {8'h0, romsel_shadow}, {8'h0, mshadow});
    chk("latch", {8'h0, latch}, {8'h0, mshadow});
  endtask

  initial forever begin
    @(posedge wclk);
    mstep();
    @(negedge wclk);
    cyc++;
    if (!reset_b) mclear();
    else begin
      // receiver latch captures on the strobe rising edge while &DFxx is decoded
      if (prev_low && ioreq_b && wr_b && adr[15:8] == 8'hDF) latch = data_out;
      if (data_oe && !prev_oe) begin
        t1_time.push_back(cyc);
        t1_rom.push_back(data_out);
      end
      prev_low = !ioreq_b && !wr_b;
      prev_oe = data_oe;
      if (chk_en) mcompare();
    end
  end

  task automatic push(input logic [7:0] v);
    bit ok, done;
    done = 0;
    req_valid = 1;
    req_rom = v;
    for (int i = 0; i < 100 && !done; i++) begin
      ok = req_ready;
      @(negedge wclk);
      #1;
      done = ok;
    end
    req_valid = 0;
    if (!done) chk("push_timeout", 16'h0, 16'h1);
  endtask

  task automatic wait_low();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge wclk);
      #1;
      done = !ioreq_b;
    end
    if (!done) chk("low_timeout", 16'h0, 16'h1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge wclk);
      #1;
      done = !busy;
    end
    if (!done) chk("idle_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge wclk);
    #1;
    chk("rst_ready", {15'h0, req_ready}, 16'h1);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_adr", adr, 16'h0000);
    chk("rst_strobes", {14'h0, ioreq_b, wr_b}, 16'h3);
    chk("rst_oe", {15'h0, data_oe}, 16'h0);
    chk("rst_shadow", {8'h0, romsel_shadow}, 16'h0);
    reset_b = 1;
    chk_en = 1;
    repeat (2) @(negedge wclk);
    #1;
    // single request: strobe low for 2+AUTO_WAIT cycles
    push(8'h07);
    wait_low();
    w = 0;
    for (int i = 0; i < 20 && !ioreq_b; i++) begin
      w++;
      chk("t1_adr", adr, 16'hDF00);
      chk("t1_data", {8'h0, data_out}, 16'h0007);
      @(negedge wclk);
      #1;
    end
    chk("t1_width", 16'(w), 16'd3);
    wait_idle();
    chk("t1_shadow", {8'h0, romsel_shadow}, 16'h0007);
    // back-to-back with simultaneous push/pop, then a held request
    t1_time.delete();
    t1_rom.delete();
    push(8'h01);
    chk("q_ready1", {15'h0, req_ready}, 16'h1);
    push(8'h02);
    chk("q_ready2", {15'h0, req_ready}, 16'h1);
    push(8'h03);
    chk("q_ready3", {15'h0, req_ready}, 16'h0);
    push(8'h04);
    wait_idle();
    chk("q_count", 16'(t1_rom.size()), 16'd4);
    for (int i = 0; i < 4 && i < t1_rom.size(); i++) begin
      chk("q_order", {8'h0, t1_rom[i]}, 16'(i + 1));
      if (i > 0) chk("q_period", 16'(t1_time[i] - t1_time[i-1]), 16'd7);
    end
    // chip select for ROM 0x0A only once its cycle completes
    push(8'h0A);
    wait_low();
    chk("cs_before", {15'h0, latch == 8'h0A}, 16'h0);
    wait_idle();
    chk("cs_after", {15'h0, latch == 8'h0A}, 16'h1);
    chk("cs_shadow", {8'h0, romsel_shadow}, 16'h000A);
    // wait_b low for four TW samples
    push(8'h0B);
    wait_low();
    w = 1;
    for (int i = 0; i < 40 && !ioreq_b; i++) begin
      @(negedge wclk);
      #1;
      if (!ioreq_b) w++;
      chk("w_data", {8'h0, data_out}, 16'h000B);
      wait_b = i >= 4;
    end
    wait_b = 1;
    chk("w_width", 16'(w), WEN ? 16'd7 : 16'd3);
    wait_idle();
    // reset during TW with another request queued
    push(8'h05);
    push(8'h06);
    wait_low();
    @(negedge wclk);
    #1;
    reset_b = 0;
    #1;
    chk("r_strobes", {14'h0, ioreq_b, wr_b}, 16'h3);
    chk("r_oe", {15'h0, data_oe}, 16'h0);
    chk("r_shadow", {8'h0, romsel_shadow}, 16'h0);
    chk("r_busy", {15'h0, busy}, 16'h0);
    chk("r_ready", {15'h0, req_ready}, 16'h1);
    repeat (2) @(negedge wclk);
    #1;
    reset_b = 1;
    t1_time.delete();
    t1_rom.delete();
    repeat (20) @(negedge wclk);
    #1;
    chk("r_no_cycles", 16'(t1_rom.size()), 16'd0);
    chk("r_idle_busy", {15'h0, busy}, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
